// File: rtl/pdm_ctrl_pkg.sv
// pdm_ctrl_pkg
//   Shared types and constants for the PDM capture controller.
//   - state_e : capture sequencer states
//   - CHAN_L / CHAN_R : values of m_chan for left / right words
package pdm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAKE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic CHAN_L = 1'b0;
    localparam logic CHAN_R = 1'b1;

endpackage

// File: rtl/pdm_word_packer.sv
// pdm_word_packer
//   Packs single-bit strobes LSB first into WORD_W-bit words. Each finished
//   word goes into a 1-deep holding register. A word that finishes while the
//   holding register is full and not being drained is dropped.
//   Ports:
//     clk, resetn    clock, asynchronous active-low reset
//     clr            synchronous clear of shifter, bit counter and holding reg
//     en             accept bit_in this cycle
//     bit_in         serial data bit
//     drain          holding register is being consumed this cycle
//     full_next      next-cycle holding register occupancy
//     word_next      next-cycle holding register contents
//     drop           a finished word was discarded this cycle
module pdm_word_packer #(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              en,
    input  logic              bit_in,
    input  logic              drain,
    output logic              full_next,
    output logic [WORD_W-1:0] word_next,
    output logic              drop
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, full_d;
    logic [WORD_W-1:0] shifted;

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        full_d  = full_q && !drain;
        drop    = 1'b0;
        // New bits enter at the MSB, so the first bit ends up at bit 0.
        shifted = {bit_in, shift_q[WORD_W-1:1]};
        if (clr) begin
            shift_d = '0;
            hold_d  = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
        end else if (en) begin
            shift_d = shifted;
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
                cnt_d = '0;
                // A drain in this same cycle has already freed the slot above.
                if (full_d) begin
                    drop = 1'b1;
                end else begin
                    hold_d = shifted;
                    full_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    assign full_next = full_d;
    assign word_next = hold_d;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl
//   Capture sequencer for a pdm_dual_recv receiver. It starts and stops
//   capture and drives the receiver mode. It discards the microphone wake-up
//   bits, then packs left/right bit strobes into words. Both channels share
//   one valid/ready output.
//   Ports:
//     clk, resetn                  clock, asynchronous active-low reset
//     start, stop, stereo          capture control (stereo sampled on start)
//     pdm_mode                     receiver mode (latched stereo while busy)
//     pdm_l_clk/stream, pdm_r_clk/stream   per-channel bit strobes and data
//     m_valid, m_ready, m_data, m_chan     packed word output (0=L, 1=R)
//     busy, running, ovf           status (ovf is sticky until next start)
//     ovf_cnt                      dropped-word count, saturating at 255;
//                                  present only with PDM_CTRL_OVF_COUNT_EN
module pdm_capture_ctrl
    import pdm_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned WAKE_BITS = 1024,
    parameter int unsigned WAKE_W    = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              stereo,
    output logic              pdm_mode,
    input  logic              pdm_l_clk,
    input  logic              pdm_l_stream,
    input  logic              pdm_r_clk,
    input  logic              pdm_r_stream,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_chan,
    output logic              busy,
    output logic              running,
`ifdef PDM_CTRL_OVF_COUNT_EN
    output logic [7:0]        ovf_cnt,
`endif
    output logic              ovf
);

    state_e            state_q, state_d;
    logic              stereo_q, stereo_d;
    logic              pdm_mode_q, pdm_mode_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic              ovf_q, ovf_d;
    logic              last_q, last_d;
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              m_chan_q, m_chan_d;
    logic              busy_q, busy_d;
    logic              running_q, running_d;

    logic              start_ok, handshake, drain_l, drain_r, en_l, en_r;
    logic              l_full_next, r_full_next, l_drop, r_drop;
    logic [WORD_W-1:0] l_word_next, r_word_next;

    always_comb begin
        start_ok  = (state_q == ST_IDLE) && start && !stop;
        handshake = m_valid_q && m_ready;
        drain_l   = handshake && (m_chan_q == CHAN_L);
        drain_r   = handshake && (m_chan_q == CHAN_R);
        en_l      = (state_q == ST_RUN) && pdm_l_clk;
        en_r      = (state_q == ST_RUN) && pdm_r_clk && stereo_q;
    end

    pdm_word_packer #(.WORD_W(WORD_W)) u_pack_l (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (start_ok),
        .en        (en_l),
        .bit_in    (pdm_l_stream),
        .drain     (drain_l),
        .full_next (l_full_next),
        .word_next (l_word_next),
        .drop      (l_drop)
    );

    pdm_word_packer #(.WORD_W(WORD_W)) u_pack_r (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (start_ok),
        .en        (en_r),
        .bit_in    (pdm_r_stream),
        .drain     (drain_r),
        .full_next (r_full_next),
        .word_next (r_word_next),
        .drop      (r_drop)
    );

    always_comb begin
        state_d    = state_q;
        stereo_d   = stereo_q;
        pdm_mode_d = pdm_mode_q;
        wake_d     = wake_q;
        ovf_d      = ovf_q || l_drop || r_drop;
        last_d     = handshake ? m_chan_q : last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d    = ST_WAKE;
                    stereo_d   = stereo;
                    pdm_mode_d = stereo;
                    ovf_d      = 1'b0;
                    wake_d     = '0;
                    // Pretend right went last so left is presented first.
                    last_d     = CHAN_R;
                end
            end
            ST_WAKE: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    pdm_mode_d = 1'b0;
                end else if (pdm_l_clk) begin
                    wake_d = wake_q + 1'b1;
                    if (wake_q == WAKE_W'(WAKE_BITS - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!l_full_next && !r_full_next) begin
                    state_d    = ST_IDLE;
                    pdm_mode_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The output register is loaded from the packers' next-cycle holding
        // state. A word finishing on this edge is therefore visible right
        // after the edge, and a just-drained slot is never re-presented.
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_chan_d  = m_chan_q;
        if (!m_valid_q || m_ready) begin
            m_valid_d = l_full_next || r_full_next;
            if (l_full_next && r_full_next) begin
                m_chan_d = (last_d == CHAN_L) ? CHAN_R : CHAN_L;
            end else if (l_full_next) begin
                m_chan_d = CHAN_L;
            end else if (r_full_next) begin
                m_chan_d = CHAN_R;
            end
            if (m_valid_d) begin
                m_data_d = (m_chan_d == CHAN_L) ? l_word_next : r_word_next;
            end
        end

        busy_d    = (state_d != ST_IDLE);
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            stereo_q   <= 1'b0;
            pdm_mode_q <= 1'b0;
            wake_q     <= '0;
            ovf_q      <= 1'b0;
            last_q     <= CHAN_R;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_chan_q   <= 1'b0;
            busy_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stereo_q   <= stereo_d;
            pdm_mode_q <= pdm_mode_d;
            wake_q     <= wake_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_chan_q   <= m_chan_d;
            busy_q     <= busy_d;
            running_q  <= running_d;
        end
    end

    assign pdm_mode = pdm_mode_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_chan   = m_chan_q;
    assign busy     = busy_q;
    assign running  = running_q;
    assign ovf      = ovf_q;

`ifdef PDM_CTRL_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic [8:0] ovf_sum;

    // Both channels can drop in the same cycle, so add up to two.
    always_comb begin
        ovf_sum   = {1'b0, ovf_cnt_q} + {8'd0, l_drop} + {8'd0, r_drop};
        ovf_cnt_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        if (start_ok) begin
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl
//   Self-checking bench for pdm_capture_ctrl (WAKE_BITS shortened to 4).
//   Optional ovf_cnt checks follow PDM_CTRL_OVF_COUNT_EN.
module tb_pdm_capture_ctrl;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned WAKE_BITS = 4;
    localparam int unsigned WAKE_W    = 3;

    logic        clk = 1'b0;
    logic        resetn, start, stop, stereo;
    logic        pdm_mode;
    logic        pdm_l_clk, pdm_l_stream, pdm_r_clk, pdm_r_stream;
    logic        m_valid, m_ready;
    logic [15:0] m_data;
    logic        m_chan, busy, running, ovf;
`ifdef PDM_CTRL_OVF_COUNT_EN
    logic [7:0]  ovf_cnt;
`endif

    always #5 clk = ~clk;

    pdm_capture_ctrl #(
        .WORD_W    (WORD_W),
        .WAKE_BITS (WAKE_BITS),
        .WAKE_W    (WAKE_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .stereo       (stereo),
        .pdm_mode     (pdm_mode),
        .pdm_l_clk    (pdm_l_clk),
        .pdm_l_stream (pdm_l_stream),
        .pdm_r_clk    (pdm_r_clk),
        .pdm_r_stream (pdm_r_stream),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_chan       (m_chan),
        .busy         (busy),
        .running      (running),
`ifdef PDM_CTRL_OVF_COUNT_EN
        .ovf_cnt      (ovf_cnt),
`endif
        .ovf          (ovf)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct packed {
        logic        chan;
        logic [15:0] data;
    } obs_t;

    obs_t obs_q[$];

    typedef struct packed {
        logic        stereo;
        logic        simul;
        logic [15:0] lw;
        logic [15:0] rw;
        logic [1:0]  n_exp;
        logic        c0;
        logic [15:0] d0;
        logic        c1;
        logic [15:0] d1;
        logic        mode;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: logs every handshake and checks that a stalled word
    // stays put until accepted.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_chan = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_stable", {15'd0, m_valid, m_chan, m_data}, {15'd0, 1'b1, prev_chan, prev_data});
            end
            if (m_valid && m_ready) begin
                obs_q.push_back({m_chan, m_data});
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_chan = m_chan;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle followed by one quiet cycle.
    task automatic strobe(input logic l, input logic lb, input logic r, input logic rb);
        pdm_l_clk    = l;
        pdm_l_stream = lb;
        pdm_r_clk    = r;
        pdm_r_stream = rb;
        tick();
        pdm_l_clk    = 1'b0;
        pdm_r_clk    = 1'b0;
        pdm_l_stream = 1'b0;
        pdm_r_stream = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic st);
        stereo = st;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("start_latency", {29'd0, busy, running, pdm_mode}, {29'd0, 1'b1, 1'b0, st});
    endtask

    task automatic wait_idle(input bit rnd);
        int unsigned n = 0;
        while (busy && n < 500) begin
            if (rnd) m_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        obs_q.delete();
        m_ready = 1'b1;
        do_start(v.stereo);
        // Wake bits are all ones so a leak into the packer would show.
        for (int k = 0; k < int'(WAKE_BITS); k++) begin
            strobe(1'b0, 1'b0, 1'b1, 1'b1);
            strobe(1'b1, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 16; k++) begin
            if (v.simul) begin
                strobe(1'b1, v.lw[k], 1'b1, v.rw[k]);
            end else begin
                strobe(1'b1, v.lw[k], 1'b0, 1'b0);
                strobe(1'b0, 1'b0, 1'b1, v.rw[k]);
            end
        end
        repeat (4) tick();
        check($sformatf("row%0d_mode", idx), {31'd0, pdm_mode}, {31'd0, v.mode});
        check($sformatf("row%0d_count", idx), obs_q.size(), {30'd0, v.n_exp});
        if (obs_q.size() >= 1) check($sformatf("row%0d_word0", idx), {15'd0, obs_q[0]}, {15'd0, v.c0, v.d0});
        if (obs_q.size() >= 2) check($sformatf("row%0d_word1", idx), {15'd0, obs_q[1]}, {15'd0, v.c1, v.d1});
        do_stop();
        wait_idle(1'b0);
        check($sformatf("row%0d_end", idx), {30'd0, busy, pdm_mode}, 32'd0);
    endtask

    // Randomized capture against a bit-list model: bits are collected per
    // channel once the wake interval has passed, and every WORD_W bits of a
    // channel make one expected word in that channel's order.
    task automatic rand_run(input int unsigned ncyc);
        logic [15:0] exp_l[$];
        logic [15:0] exp_r[$];
        logic [15:0] lacc = '0, racc = '0;
        int unsigned lnum = 0, rnum = 0, lcnt = 0;
        logic        st, l, r, lb, rb;
        obs_t        o;
        obs_q.delete();
        st = 1'($urandom_range(0, 1));
        do_start(st);
        for (int unsigned c = 0; c < ncyc; c++) begin
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            lb = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            pdm_l_clk = l; pdm_l_stream = lb;
            pdm_r_clk = r; pdm_r_stream = rb;
            m_ready = ($urandom_range(0, 3) != 0);
            if (lcnt < WAKE_BITS) begin
                if (l) lcnt++;
            end else begin
                if (l) begin
                    lacc[lnum] = lb;
                    lnum++;
                    if (lnum == WORD_W) begin exp_l.push_back(lacc); lnum = 0; end
                end
                if (r && st) begin
                    racc[rnum] = rb;
                    rnum++;
                    if (rnum == WORD_W) begin exp_r.push_back(racc); rnum = 0; end
                end
            end
            tick();
        end
        pdm_l_clk = 1'b0; pdm_r_clk = 1'b0;
        tick();
        do_stop();
        wait_idle(1'b1);
        m_ready = 1'b1;
        check("rand_ovf", {31'd0, ovf}, 32'd0);
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            if (o.chan == 1'b0) begin
                check("rand_l_avail", {31'd0, exp_l.size() != 0}, 32'd1);
                if (exp_l.size() != 0) check("rand_l_word", {16'd0, o.data}, {16'd0, exp_l.pop_front()});
            end else begin
                check("rand_r_avail", {31'd0, exp_r.size() != 0}, 32'd1);
                if (exp_r.size() != 0) check("rand_r_word", {16'd0, o.data}, {16'd0, exp_r.pop_front()});
            end
        end
        check("rand_leftover", exp_l.size() + exp_r.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;

        //           stereo simul lw        rw        n  c0   d0        c1   d1        mode
        vecs[0] = '{1'b1, 1'b0, 16'hAAAA, 16'h3333, 2'd2, 1'b0, 16'hAAAA, 1'b1, 16'h3333, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 16'hAAAA, 16'h3333, 2'd1, 1'b0, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h1234, 16'h8001, 2'd2, 1'b0, 16'h1234, 1'b1, 16'h8001, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 2'd1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h0001, 16'hFFFE, 2'd2, 1'b0, 16'h0001, 1'b1, 16'hFFFE, 1'b1};

        resetn = 1'b0; start = 1'b0; stop = 1'b0; stereo = 1'b0;
        pdm_l_clk = 1'b0; pdm_l_stream = 1'b0; pdm_r_clk = 1'b0; pdm_r_stream = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        check("reset_outs", {10'd0, pdm_mode, m_valid, m_chan, busy, running, ovf, m_data}, 32'd0);
`ifdef PDM_CTRL_OVF_COUNT_EN
        check("reset_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
        resetn = 1'b1;
        tick();

        // Start and stop together in IDLE are both ignored.
        stereo = 1'b1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_same", {30'd0, busy, pdm_mode}, 32'd0);
        tick();
        check("start_stop_after", {30'd0, busy, pdm_mode}, 32'd0);

        for (int i = 0; i < 5; i++) run_row(vecs[i], i);

        // Backpressure: three left words with m_ready low, two get dropped.
        obs_q.delete();
        m_ready = 1'b0;
        do_start(1'b0);
        for (int k = 0; k < int'(WAKE_BITS); k++) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        w = 16'h1357;
        for (int k = 0; k < 16; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        w = 16'h2468;
        for (int k = 0; k < 16; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        w = 16'hBEEF;
        for (int k = 0; k < 16; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        check("bp_held", {15'd0, m_valid, m_chan, m_data}, {15'd0, 1'b1, 1'b0, 16'h1357});
        check("bp_ovf", {31'd0, ovf}, 32'd1);
`ifdef PDM_CTRL_OVF_COUNT_EN
        check("bp_ovf_cnt", {24'd0, ovf_cnt}, 32'd2);
`endif
        check("bp_none_yet", obs_q.size(), 32'd0);
        m_ready = 1'b1;
        repeat (3) tick();
        check("bp_count", obs_q.size(), 32'd1);
        if (obs_q.size() >= 1) check("bp_word", {15'd0, obs_q[0]}, {15'd0, 1'b0, 16'h1357});
        check("bp_valid_low", {31'd0, m_valid}, 32'd0);
        do_stop();
        wait_idle(1'b0);
        check("bp_ovf_sticky", {31'd0, ovf}, 32'd1);

        // Stop mid-word with one full word pending.
        obs_q.delete();
        m_ready = 1'b0;
        do_start(1'b1);
        check("stop_ovf_cleared", {31'd0, ovf}, 32'd0);
`ifdef PDM_CTRL_OVF_COUNT_EN
        check("stop_ovf_cnt_cleared", {24'd0, ovf_cnt}, 32'd0);
`endif
        for (int k = 0; k < int'(WAKE_BITS); k++) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        w = 16'hC0DE;
        for (int k = 0; k < 16; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        w = 16'h5A5A;
        for (int k = 0; k < 8; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        do_stop();
        check("stop_drain", {29'd0, busy, running, pdm_mode}, {29'd0, 1'b1, 1'b0, 1'b1});
        m_ready = 1'b1;
        wait_idle(1'b0);
        check("stop_count", obs_q.size(), 32'd1);
        if (obs_q.size() >= 1) check("stop_word", {15'd0, obs_q[0]}, {15'd0, 1'b0, 16'hC0DE});
        check("stop_mode", {31'd0, pdm_mode}, 32'd0);
        // A fresh capture must not inherit the discarded partial bits.
        obs_q.delete();
        do_start(1'b0);
        for (int k = 0; k < int'(WAKE_BITS); k++) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        w = 16'h0F0F;
        for (int k = 0; k < 16; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        tick();
        check("restart_count", obs_q.size(), 32'd1);
        if (obs_q.size() >= 1) check("restart_word", {15'd0, obs_q[0]}, {15'd0, 1'b0, 16'h0F0F});
        do_stop();
        wait_idle(1'b0);

        // Word latency, then asynchronous reset with m_valid high.
        m_ready = 1'b0;
        do_start(1'b1);
        for (int k = 0; k < int'(WAKE_BITS); k++) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        w = 16'h9ABC;
        for (int k = 0; k < 15; k++) strobe(1'b1, w[k], 1'b0, 1'b0);
        check("latency_pre", {31'd0, m_valid}, 32'd0);
        pdm_l_clk = 1'b1; pdm_l_stream = w[15];
        tick();
        pdm_l_clk = 1'b0; pdm_l_stream = 1'b0;
        check("word_latency", {15'd0, m_valid, m_chan, m_data}, {15'd0, 1'b1, 1'b0, 16'h9ABC});
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_outs", {10'd0, pdm_mode, m_valid, m_chan, busy, running, ovf, m_data}, 32'd0);
`ifdef PDM_CTRL_OVF_COUNT_EN
        check("async_reset_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
`endif
        #10;
        resetn = 1'b1;
        tick();
        check("post_reset_idle", {27'd0, busy, running, pdm_mode, m_valid, ovf}, 32'd0);

        for (int i = 0; i < 4; i++) rand_run(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
